// File: rtl/reset_sequencer.sv
// Reset sequencer: releases NUM_DOMAINS active-high domain resets one at a
// time, in bit order, once the PLL has locked and a hold period has elapsed.
// Any lock loss or software reset request re-asserts every domain at once.
//
// Optional build macro RSTSEQ_WDOG_EN adds a lock watchdog: if lock is not
// seen within LOCK_TIMEOUT cycles, o_lock_timeout latches high and the
// sequence proceeds while ignoring the lock status from then on.
module reset_sequencer #(
    parameter int NUM_DOMAINS      = 4,
    parameter int HOLD_CYCLES      = 16,
    parameter int STEP_CYCLES      = 8,
    parameter int LOCK_SYNC_STAGES = 2,
    parameter int LOCK_TIMEOUT     = 1024
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_pll_locked,
    input  logic                   i_sw_rst,
    output logic [NUM_DOMAINS-1:0] o_rst,
    output logic                   o_done,
    output logic                   o_lock_timeout
);

    localparam int HS_MAX  = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_MAX = (HS_MAX > LOCK_TIMEOUT) ? HS_MAX : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        HOLD,
        RELEASE,
        DONE
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [IDX_W-1:0]            idx;
    logic [LOCK_SYNC_STAGES-1:0] lock_sync;
    logic                        lock_s;
    logic                        lock_ok;

    // Bring the asynchronous PLL lock status into the clk domain.
    // NOTE: sequential state is always assigned with <= so every flop in the
    // chain samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[LOCK_SYNC_STAGES-2:0], i_pll_locked};
        end
    end

    assign lock_s = lock_sync[LOCK_SYNC_STAGES-1];

`ifdef RSTSEQ_WDOG_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    // Once the watchdog has fired, lock status no longer gates entry or abort.
    assign lock_ok = lock_s | o_lock_timeout;

    // Sticky watchdog flag: set when WAIT_LOCK has waited LOCK_TIMEOUT cycles.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lock_timeout <= 1'b0;
        end else if (state == WAIT_LOCK && !i_sw_rst && !lock_ok && cnt == TIMEOUT_LAST) begin
            o_lock_timeout <= 1'b1;
        end
    end
`else
    assign lock_ok        = lock_s;
    assign o_lock_timeout = 1'b0;
`endif

    // Release sequencing FSM; abort on lock loss or software reset wins.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= WAIT_LOCK;
            o_rst  <= '1;
            o_done <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
        end else if (state != WAIT_LOCK && (i_sw_rst || !lock_ok)) begin
            state  <= WAIT_LOCK;
            o_rst  <= '1;
            o_done <= 1'b0;
            cnt    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    o_rst  <= '1;
                    o_done <= 1'b0;
                    if (i_sw_rst) begin
                        cnt <= '0;
                    end else if (lock_ok) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end
`ifdef RSTSEQ_WDOG_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
`endif
                end
                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state    <= RELEASE;
                        o_rst[0] <= 1'b0;
                        idx      <= '0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == STEP_LAST) begin
                        cnt <= '0;
                        if (idx != IDX_LAST) begin
                            idx                    <= idx + IDX_W'(1);
                            o_rst[idx + IDX_W'(1)] <= 1'b0;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Outputs hold until an abort or i_rst_n.
                end
                default: begin
                    state <= WAIT_LOCK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer (NUM_DOMAINS=4, HOLD=16, STEP=8, 2 sync
// stages). Inputs change 1 time unit after a rising edge; outputs are sampled
// at that same point, before the new inputs are applied. Edge 0 of a
// sequence is the edge right before i_pll_locked (or i_rst_n) goes high, so
// o_rst[k] falls 19 + 8*k edges later. Build with RSTSEQ_WDOG_EN to include
// the watchdog sequence.
module tb_reset_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int STEP = 8;
    localparam int SYNC = 2;
    localparam int TMO  = 100;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         pll_locked = 1'b0;
    logic         sw_rst     = 1'b0;
    logic [N-1:0] rst;
    logic         done;
    logic         lock_timeout;

    reset_sequencer #(
        .NUM_DOMAINS     (N),
        .HOLD_CYCLES     (HOLD),
        .STEP_CYCLES     (STEP),
        .LOCK_SYNC_STAGES(SYNC),
        .LOCK_TIMEOUT    (TMO)
    ) dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_pll_locked  (pll_locked),
        .i_sw_rst      (sw_rst),
        .o_rst         (rst),
        .o_done        (done),
        .o_lock_timeout(lock_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] rst;
        logic         done;
    } exp_t;

    typedef struct {
        logic         lock;
        logic         sw;
        int           adv;
        logic [N-1:0] rst;
        logic         done;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive inputs, queue the expectation, advance n edges, compare.
    task automatic step(input string name, input logic lock, input logic sw, input int n,
                        input logic [N-1:0] er, input logic ed);
        exp_t e;
        exp_t got;
        pll_locked = lock;
        sw_rst     = sw;
        e.rst      = er;
        e.done     = ed;
        sb.push_back(e);
        tick(n);
        got = sb.pop_front();
        check(name, {3'b0, rst, done}, {3'b0, got.rst, got.done});
    endtask

    initial begin
        // Nominal sequence after reset release with lock initially low.
        vecs = '{
            '{1'b0, 1'b0,  5, 4'hF, 1'b0},
            '{1'b0, 1'b0, 50, 4'hF, 1'b0},
            '{1'b1, 1'b0, 18, 4'hF, 1'b0},
            '{1'b1, 1'b0,  1, 4'hE, 1'b0},
            '{1'b1, 1'b0,  7, 4'hE, 1'b0},
            '{1'b1, 1'b0,  1, 4'hC, 1'b0},
            '{1'b1, 1'b0,  7, 4'hC, 1'b0},
            '{1'b1, 1'b0,  1, 4'h8, 1'b0},
            '{1'b1, 1'b0,  7, 4'h8, 1'b0},
            '{1'b1, 1'b0,  1, 4'h0, 1'b0},
            '{1'b1, 1'b0,  7, 4'h0, 1'b0},
            '{1'b1, 1'b0,  1, 4'h0, 1'b1},
            '{1'b1, 1'b0, 20, 4'h0, 1'b1}
        };

        // Power-up: reset held while lock toggles.
        for (int i = 0; i < 6; i++) begin
            step($sformatf("in_reset[%0d]", i), 1'(i % 2), 1'b0, 1, 4'hF, 1'b0);
        end
        check("in_reset_timeout", {7'b0, lock_timeout}, 8'h00);

        pll_locked = 1'b0;
        rst_n      = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step($sformatf("nominal[%0d]", i), vecs[i].lock, vecs[i].sw, vecs[i].adv,
                 vecs[i].rst, vecs[i].done);
        end

        // Software reset pulse in DONE: abort next edge, o_rst[0] 17 edges later.
        step("sw_abort",     1'b1, 1'b1,  1, 4'hF, 1'b0);
        step("sw_hold_end",  1'b1, 1'b0, 16, 4'hF, 1'b0);
        step("sw_rel0",      1'b1, 1'b0,  1, 4'hE, 1'b0);
        step("sw_rel1",      1'b1, 1'b0,  8, 4'hC, 1'b0);

        // One-cycle lock glitch in RELEASE.
        step("glitch_low",   1'b0, 1'b0,  1, 4'hC, 1'b0);
        step("glitch_sync",  1'b1, 1'b0,  1, 4'hC, 1'b0);
        step("glitch_abort", 1'b1, 1'b0,  1, 4'hF, 1'b0);
        step("glitch_hold",  1'b1, 1'b0, 16, 4'hF, 1'b0);
        step("glitch_rel0",  1'b1, 1'b0,  1, 4'hE, 1'b0);
        step("glitch_rel3",  1'b1, 1'b0, 24, 4'h0, 1'b0);
        step("glitch_done",  1'b1, 1'b0,  8, 4'h0, 1'b1);

        // Lock loss and software reset seen on the same edge.
        step("both_pre",     1'b0, 1'b0,  2, 4'h0, 1'b1);
        step("both_abort",   1'b0, 1'b1,  1, 4'hF, 1'b0);
        step("both_hold",    1'b1, 1'b0, 18, 4'hF, 1'b0);
        step("both_rel0",    1'b1, 1'b0,  1, 4'hE, 1'b0);

        // Async reset between edges while in RELEASE.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_release", {3'b0, rst, done}, {3'b0, 4'hF, 1'b0});
        tick(2);
        rst_n = 1'b1;
        step("after_async_hold", 1'b1, 1'b0, 18, 4'hF, 1'b0);
        step("after_async_rel0", 1'b1, 1'b0,  1, 4'hE, 1'b0);

        // Async reset mid-HOLD; counters and synchronizer must restart cleanly.
        step("to_hold_abort", 1'b1, 1'b1, 1, 4'hF, 1'b0);
        step("mid_hold",      1'b1, 1'b0, 5, 4'hF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_hold", {3'b0, rst, done}, {3'b0, 4'hF, 1'b0});
        tick(2);
        rst_n = 1'b1;
        step("rehold",      1'b1, 1'b0, 18, 4'hF, 1'b0);
        step("rehold_rel0", 1'b1, 1'b0,  1, 4'hE, 1'b0);

`ifdef RSTSEQ_WDOG_EN
        // Watchdog: lock held low after reset release.
        @(negedge clk);
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(99);
        check("wdog_pre",  {7'b0, lock_timeout}, 8'h00);
        tick(1);
        check("wdog_fire", {7'b0, lock_timeout}, 8'h01);
        step("wdog_hold",  1'b0, 1'b0, 15, 4'hF, 1'b0);
        step("wdog_rel0",  1'b0, 1'b0,  1, 4'hE, 1'b0);
        step("wdog_tog1",  1'b1, 1'b0, 10, 4'hC, 1'b0);
        step("wdog_tog2",  1'b0, 1'b0, 10, 4'h8, 1'b0);
        step("wdog_done",  1'b1, 1'b0, 12, 4'h0, 1'b1);
        check("wdog_sticky", {7'b0, lock_timeout}, 8'h01);
`else
        check("no_wdog", {7'b0, lock_timeout}, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
